// File: rtl/tile_pkg.sv
// Tile definitions shared by the tilemap writer and the background renderer:
// screen geometry, tile IDs and the writer command opcodes.
package tile_pkg;

   localparam int NUM_TILES_X    = 40;
   localparam int NUM_TILES_Y    = 25;
   localparam int TILE_IDX_WIDTH = 5;

   typedef enum logic [TILE_IDX_WIDTH-1:0] {
      TILE_GRASS     = 5'd0,
      TILE_WATER     = 5'd1,
      TILE_ROAD0     = 5'd2,
      TILE_ROAD1     = 5'd3,
      TILE_ROAD2     = 5'd4,
      TILE_ROAD3     = 5'd5,
      TILE_ROAD4_0   = 5'd6,
      TILE_ROAD4_90  = 5'd7,
      TILE_ROAD4_180 = 5'd8,
      TILE_ROAD4_270 = 5'd9,
      TILE_ROAD5_0   = 5'd10,
      TILE_ROAD5_90  = 5'd11,
      TILE_ROAD5_180 = 5'd12,
      TILE_ROAD5_270 = 5'd13,
      TILE_ROAD6_0   = 5'd14,
      TILE_ROAD6_90  = 5'd15,
      TILE_ROAD6_180 = 5'd16,
      TILE_ROAD6_270 = 5'd17,
      TILE_ROAD7_0   = 5'd18,
      TILE_ROAD7_90  = 5'd19,
      TILE_ROAD7_180 = 5'd20,
      TILE_ROAD7_270 = 5'd21
   } tile_id_e;

   localparam int MAX_TILE_ID = int'(TILE_ROAD7_270);

   typedef enum logic [1:0] {
      OP_WRITE     = 2'b00,
      OP_FILL      = 2'b01,
      OP_CLEAR_ALL = 2'b10,
      OP_RESERVED  = 2'b11
   } cmd_op_e;

endpackage

// File: rtl/tile_rect_cursor.sv
// Raster cursor over an inclusive rectangle, x fastest; last_o flags the final
// coordinate so the caller can finish on the same edge as the last write.
module tile_rect_cursor #(
   parameter int XW = 6,
   parameter int YW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_i,
   input  logic          advance_i,
   input  logic [XW-1:0] x0_i,
   input  logic [XW-1:0] x1_i,
   input  logic [YW-1:0] y0_i,
   input  logic [YW-1:0] y1_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          last_o
);

   logic [XW-1:0] x_q, x_d, x0_q, x0_d, x1_q, x1_d;
   logic [YW-1:0] y_q, y_d, y1_q, y1_d;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      x_d  = x_q;
      y_d  = y_q;
      x0_d = x0_q;
      x1_d = x1_q;
      y1_d = y1_q;
      if (load_i) begin
         x_d  = x0_i;
         y_d  = y0_i;
         x0_d = x0_i;
         x1_d = x1_i;
         y1_d = y1_i;
      end else if (advance_i) begin
         if (x_q == x1_q) begin
            x_d = x0_q;
            y_d = y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         x_q  <= '0;
         y_q  <= '0;
         x0_q <= '0;
         x1_q <= '0;
         y1_q <= '0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         x0_q <= x0_d;
         x1_q <= x1_d;
         y1_q <= y1_d;
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/tilemap_writer.sv
// Tilemap writer: single-tile writes, rectangle fills and full clears into a
// registered tile array, plus a one-cycle-latency readback port.
module tilemap_writer #(
   parameter int NUM_TILES_X       = tile_pkg::NUM_TILES_X,
   parameter int NUM_TILES_Y       = tile_pkg::NUM_TILES_Y,
   parameter int TILE_IDX_WIDTH    = tile_pkg::TILE_IDX_WIDTH,
   parameter int ADDR_TILES_X_SIZE = 6,
   parameter int ADDR_TILES_Y_SIZE = 5,
   parameter int MAX_TILE_ID       = tile_pkg::MAX_TILE_ID,
   parameter int CLEAR_TILE        = int'(tile_pkg::TILE_GRASS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_op,
   input  logic [ADDR_TILES_X_SIZE-1:0] cmd_x0,
   input  logic [ADDR_TILES_X_SIZE-1:0] cmd_x1,
   input  logic [ADDR_TILES_Y_SIZE-1:0] cmd_y0,
   input  logic [ADDR_TILES_Y_SIZE-1:0] cmd_y1,
   input  logic [TILE_IDX_WIDTH-1:0]    cmd_tile,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [0:NUM_TILES_Y-1][0:NUM_TILES_X-1][TILE_IDX_WIDTH-1:0] tilemap,
   input  logic [ADDR_TILES_X_SIZE-1:0] rd_x,
   input  logic [ADDR_TILES_Y_SIZE-1:0] rd_y,
   output logic [TILE_IDX_WIDTH-1:0]    rd_tile
);

   import tile_pkg::*;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_CLEAR} state_e;

   localparam logic [TILE_IDX_WIDTH-1:0]    CLEAR_VAL = TILE_IDX_WIDTH'(CLEAR_TILE);
   localparam logic [ADDR_TILES_X_SIZE-1:0] X_LAST    = ADDR_TILES_X_SIZE'(NUM_TILES_X - 1);
   localparam logic [ADDR_TILES_Y_SIZE-1:0] Y_LAST    = ADDR_TILES_Y_SIZE'(NUM_TILES_Y - 1);

   state_e                        state_q, state_d;
   logic [TILE_IDX_WIDTH-1:0]     fill_tile_q, fill_tile_d;
   logic                          done_wr_q, done_wr_d;
   logic                          err_q, err_d;
   logic [0:NUM_TILES_Y-1][0:NUM_TILES_X-1][TILE_IDX_WIDTH-1:0] tilemap_q;
   logic [TILE_IDX_WIDTH-1:0]     rd_tile_q;

   cmd_op_e                       op;
   logic                          tile_bad, x0_bad, x1_bad, y0_bad, y1_bad, cmd_bad;
   logic                          rd_in_range;

   logic                          wr_en;
   logic [ADDR_TILES_X_SIZE-1:0]  wr_x;
   logic [ADDR_TILES_Y_SIZE-1:0]  wr_y;
   logic [TILE_IDX_WIDTH-1:0]     wr_tile;

   logic                          cur_load, cur_adv, cur_last;
   logic [ADDR_TILES_X_SIZE-1:0]  cur_x0, cur_x1, cur_x;
   logic [ADDR_TILES_Y_SIZE-1:0]  cur_y0, cur_y1, cur_y;

   assign op          = cmd_op_e'(cmd_op);
   assign tile_bad    = 32'(cmd_tile) > MAX_TILE_ID;
   assign x0_bad      = 32'(cmd_x0) >= NUM_TILES_X;
   assign x1_bad      = 32'(cmd_x1) >= NUM_TILES_X;
   assign y0_bad      = 32'(cmd_y0) >= NUM_TILES_Y;
   assign y1_bad      = 32'(cmd_y1) >= NUM_TILES_Y;
   assign rd_in_range = (32'(rd_x) < NUM_TILES_X) && (32'(rd_y) < NUM_TILES_Y);

   always_comb begin
      cmd_bad = 1'b1;
      case (op)
         OP_WRITE:     cmd_bad = tile_bad || x0_bad || y0_bad;
         OP_FILL:      cmd_bad = tile_bad || x0_bad || x1_bad || y0_bad || y1_bad ||
                                 (cmd_x1 < cmd_x0) || (cmd_y1 < cmd_y0);
         OP_CLEAR_ALL: cmd_bad = 1'b0;
         default:      cmd_bad = 1'b1;
      endcase
   end

   tile_rect_cursor #(
      .XW (ADDR_TILES_X_SIZE),
      .YW (ADDR_TILES_Y_SIZE)
   ) u_cursor (
      .clk       (clk),
      .rst       (rst),
      .load_i    (cur_load),
      .advance_i (cur_adv),
      .x0_i      (cur_x0),
      .x1_i      (cur_x1),
      .y0_i      (cur_y0),
      .y1_i      (cur_y1),
      .x_o       (cur_x),
      .y_o       (cur_y),
      .last_o    (cur_last)
   );

   always_comb begin
      state_d     = state_q;
      fill_tile_d = fill_tile_q;
      done_wr_d   = 1'b0;
      err_d       = 1'b0;
      wr_en       = 1'b0;
      wr_x        = cur_x;
      wr_y        = cur_y;
      wr_tile     = fill_tile_q;
      cur_load    = 1'b0;
      cur_adv     = 1'b0;
      cur_x0      = cmd_x0;
      cur_x1      = cmd_x1;
      cur_y0      = cmd_y0;
      cur_y1      = cmd_y1;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_bad) begin
                  err_d = 1'b1;
               end else begin
                  case (op)
                     OP_WRITE: begin
                        wr_en     = 1'b1;
                        wr_x      = cmd_x0;
                        wr_y      = cmd_y0;
                        wr_tile   = cmd_tile;
                        done_wr_d = 1'b1;
                     end
                     OP_FILL: begin
                        cur_load    = 1'b1;
                        fill_tile_d = cmd_tile;
                        state_d     = S_FILL;
                     end
                     OP_CLEAR_ALL: begin
                        cur_load = 1'b1;
                        cur_x0   = '0;
                        cur_x1   = X_LAST;
                        cur_y0   = '0;
                        cur_y1   = Y_LAST;
                        state_d  = S_CLEAR;
                     end
                     default: err_d = 1'b1;
                  endcase
               end
            end
         end
         // Multi-cycle ops write the cursor position and leave on the last write.
         S_FILL, S_CLEAR: begin
            wr_en   = 1'b1;
            wr_tile = (state_q == S_CLEAR) ? CLEAR_VAL : fill_tile_q;
            cur_adv = 1'b1;
            if (cur_last) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         fill_tile_q <= '0;
         done_wr_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_tile_q <= fill_tile_d;
         done_wr_q   <= done_wr_d;
         err_q       <= err_d;
      end
   end

   // NOTE: the tile array is reset because the renderer reads it directly and
   // must never see uninitialised tiles; it is flops, not a RAM macro.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int y = 0; y < NUM_TILES_Y; y++) begin
            for (int x = 0; x < NUM_TILES_X; x++) begin
               tilemap_q[y][x] <= CLEAR_VAL;
            end
         end
         rd_tile_q <= CLEAR_VAL;
      end else begin
         if (wr_en) tilemap_q[wr_y][wr_x] <= wr_tile;
         rd_tile_q <= rd_in_range ? tilemap_q[rd_y][rd_x] : CLEAR_VAL;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = done_wr_q || (busy && cur_last);
   assign err       = err_q;
   assign tilemap   = tilemap_q;
   assign rd_tile   = rd_tile_q;

endmodule

// File: tb/tb_tilemap_writer.sv
// Bench for tilemap_writer: directed and random commands against a tile-array
// model; a monitor pops expected responses whenever done or err pulses.
module tb_tilemap_writer;

   import tile_pkg::*;

   localparam int NX   = 40;
   localparam int NY   = 25;
   localparam int TW   = 5;
   localparam int XW   = 6;
   localparam int YW   = 5;
   localparam int MAXT = 21;

   typedef logic [0:NY-1][0:NX-1][TW-1:0] map_t;

   typedef struct {
      bit   is_err;
      int   latency;
      int   busy_cycles;
      int   acc_cyc;
      map_t snap;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [1:0]    cmd_op;
   logic [XW-1:0] cmd_x0, cmd_x1;
   logic [YW-1:0] cmd_y0, cmd_y1;
   logic [TW-1:0] cmd_tile;
   logic          busy, done, err;
   map_t          tilemap;
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic [TW-1:0] rd_tile;

   exp_t exp_q[$];
   int   model[NY][NX];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   mon_busy = 1'b0;

   tilemap_writer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_x0    (cmd_x0),
      .cmd_x1    (cmd_x1),
      .cmd_y0    (cmd_y0),
      .cmd_y1    (cmd_y1),
      .cmd_tile  (cmd_tile),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .tilemap   (tilemap),
      .rd_x      (rd_x),
      .rd_y      (rd_y),
      .rd_tile   (rd_tile)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation ran past its time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_map(input string name, input map_t actual, input map_t expected);
      bit reported = 1'b0;
      checks++;
      if (actual !== expected) begin
         errors++;
         for (int y = 0; y < NY; y++) begin
            for (int x = 0; x < NX; x++) begin
               if (!reported && actual[y][x] !== expected[y][x]) begin
                  $display("FAIL %s: first difference at (x=%0d,y=%0d) got %0d, expected %0d",
                           name, x, y, actual[y][x], expected[y][x]);
                  reported = 1'b1;
               end
            end
         end
      end
   endtask

   function automatic map_t snap_model();
      map_t m;
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++)
            m[y][x] = TW'(model[y][x]);
      return m;
   endfunction

   task automatic clear_model();
      for (int y = 0; y < NY; y++)
         for (int x = 0; x < NX; x++)
            model[y][x] = 0;
   endtask

   // Expected response follows the command rules directly, then the model is updated.
   task automatic send(input logic [1:0] op, input int x0, input int x1, input int y0,
                       input int y1, input int tile, input bit track);
      exp_t e;
      bit   bad;
      case (op)
         2'b00:   bad = (tile > MAXT) || (x0 >= NX) || (y0 >= NY);
         2'b01:   bad = (tile > MAXT) || (x0 >= NX) || (x1 >= NX) || (y0 >= NY) ||
                        (y1 >= NY) || (x1 < x0) || (y1 < y0);
         2'b10:   bad = 1'b0;
         default: bad = 1'b1;
      endcase
      e.is_err      = bad;
      e.latency     = 1;
      e.busy_cycles = 0;
      if (!bad && track) begin
         if (op == 2'b00) begin
            model[y0][x0] = tile;
         end else if (op == 2'b01) begin
            for (int y = y0; y <= y1; y++)
               for (int x = x0; x <= x1; x++)
                  model[y][x] = tile;
            e.latency     = (x1 - x0 + 1) * (y1 - y0 + 1);
            e.busy_cycles = e.latency;
         end else begin
            clear_model();
            e.latency     = NX * NY;
            e.busy_cycles = NX * NY;
         end
      end
      e.snap    = snap_model();
      cmd_op    = op;
      cmd_x0    = XW'(x0);
      cmd_x1    = XW'(x1);
      cmd_y0    = YW'(y0);
      cmd_y1    = YW'(y1);
      cmd_tile  = TW'(tile);
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (track) begin
         e.acc_cyc = cyc;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         if (exp_q.size() == 0 && !mon_busy && cmd_ready) return;
         @(posedge clk);
         #1;
      end
      check("idle_timeout", 1, 0);
      exp_q.delete();
   endtask

   task automatic rd_check(input int x, input int y);
      int exp_v;
      rd_x = XW'(x);
      rd_y = YW'(y);
      @(posedge clk);
      #1;
      exp_v = 0;
      if (x < NX && y < NY) exp_v = model[y][x];
      check("rd_tile", rd_tile, exp_v);
   endtask

   task automatic fill_order_test();
      int             xs[$], ys[$];
      int             oldv[6];
      logic [29:0]    exp_v, act_v;
      for (int y = 1; y <= 2; y++)
         for (int x = 2; x <= 4; x++) begin
            xs.push_back(x);
            ys.push_back(y);
         end
      for (int i = 0; i < 6; i++) oldv[i] = model[ys[i]][xs[i]];
      send(OP_FILL, 2, 4, 1, 2, 3, 1'b1);
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < 6; i++) begin
            exp_v[i*5 +: 5] = (i < k) ? TW'(3) : TW'(oldv[i]);
            act_v[i*5 +: 5] = tilemap[ys[i]][xs[i]];
         end
         check("fill_raster_order", act_v, exp_v);
         check("fill_busy_not_ready", {busy, cmd_ready}, 2'b10);
         @(posedge clk);
         #1;
      end
      check("fill_idle_after", {busy, cmd_ready}, 2'b01);
   endtask

   task automatic random_cmd();
      int         sel, x0, x1, y0, y1, tile;
      logic [1:0] op;
      sel  = $urandom_range(0, 9);
      x0   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
      y0   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(25, 31)) : int'($urandom_range(0, 24));
      x1   = ($urandom_range(0, 7) == 0) ? x0 - 1 : x0 + int'($urandom_range(0, 3));
      y1   = ($urandom_range(0, 7) == 0) ? y0 - 1 : y0 + int'($urandom_range(0, 3));
      if (x1 < 0) x1 = 0;
      if (x1 > 63) x1 = 63;
      if (y1 < 0) y1 = 0;
      if (y1 > 31) y1 = 31;
      tile = $urandom_range(0, 23);
      op   = (sel < 5) ? OP_WRITE : (sel < 9) ? OP_FILL : OP_RESERVED;
      wait_idle();
      send(op, x0, x1, y0, y1, tile, 1'b1);
      wait_idle();
      if ($urandom_range(0, 1) == 1)
         rd_check($urandom_range(0, 45), $urandom_range(0, 27));
   endtask

   // Response monitor: one expected entry per done/err pulse.
   initial begin
      exp_t e;
      int   busy_cnt;
      busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            busy_cnt = 0;
            continue;
         end
         if (busy) busy_cnt++;
         if (done || err) begin
            check("done_err_exclusive", done & err, 0);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 1, 0);
            end else begin
               mon_busy = 1'b1;
               e = exp_q.pop_front();
               check("pulse_is_err", err, e.is_err);
               check("pulse_latency", cyc - e.acc_cyc + 1, e.latency);
               check("busy_cycles", busy_cnt, e.busy_cycles);
               check("ready_not_busy", cmd_ready, !busy);
               @(posedge clk);
               #1;
               check_map("tilemap_after_cmd", tilemap, e.snap);
               mon_busy = 1'b0;
            end
            busy_cnt = 0;
         end
      end
   end

   initial begin
      int old_v;
      rst       = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_x0    = '0;
      cmd_x1    = '0;
      cmd_y0    = '0;
      cmd_y1    = '0;
      cmd_tile  = '0;
      rd_x      = '0;
      rd_y      = '0;
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_err", err, 0);
      check("reset_rd_tile", rd_tile, 0);
      check_map("reset_tilemap", tilemap, snap_model());

      // Single write, with a read of the same tile on the write edge.
      rd_x  = 5;
      rd_y  = 3;
      old_v = model[3][5];
      send(OP_WRITE, 5, 0, 3, 0, 7, 1'b1);
      check("rd_same_edge_old", rd_tile, old_v);
      @(posedge clk);
      #1;
      check("rd_after_write", rd_tile, 7);
      wait_idle();

      fill_order_test();
      wait_idle();

      // Rejected commands.
      send(OP_WRITE, 40, 0, 0, 0, 1, 1'b1);
      wait_idle();
      send(OP_WRITE, 1, 0, 1, 0, 22, 1'b1);
      wait_idle();
      send(OP_FILL, 3, 1, 0, 0, 2, 1'b1);
      wait_idle();
      send(OP_RESERVED, 0, 0, 0, 0, 0, 1'b1);
      wait_idle();
      send(OP_FILL, 38, 40, 0, 0, 2, 1'b1);
      wait_idle();
      send(OP_FILL, 0, 0, 23, 25, 2, 1'b1);
      wait_idle();
      send(OP_WRITE, 0, 0, 25, 0, 2, 1'b1);
      wait_idle();

      // Boundary-legal commands.
      send(OP_WRITE, 39, 0, 24, 0, 21, 1'b1);
      wait_idle();
      send(OP_FILL, 20, 20, 10, 10, 9, 1'b1);
      wait_idle();
      send(OP_FILL, 36, 39, 22, 24, 13, 1'b1);
      wait_idle();
      rd_check(39, 24);
      rd_check(45, 3);
      rd_check(5, 27);

      for (int n = 0; n < 40; n++) random_cmd();

      wait_idle();
      send(OP_CLEAR_ALL, 0, 0, 0, 0, 0, 1'b1);
      wait_idle();
      rd_check(5, 3);

      // Reset in the third cycle of a six-tile fill aborts it.
      send(OP_FILL, 10, 12, 5, 6, 4, 1'b1);
      exp_q.delete();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      clear_model();
      check("abort_cmd_ready", cmd_ready, 1);
      check("abort_busy", busy, 0);
      check("abort_done_err", {done, err}, 2'b00);
      check("abort_rd_tile", rd_tile, 0);
      check_map("abort_tilemap", tilemap, snap_model());
      repeat (8) @(posedge clk);
      #1;
      check_map("abort_tilemap_stable", tilemap, snap_model());
      send(OP_WRITE, 0, 0, 0, 0, 5, 1'b1);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
